axis_slip_decoder: RTL and testbench
====================================

// Module: axis_slip_decoder
// PURPOSE
//   Downstream stage of the RS232 byte receiver. Consumes the raw 8-bit AXI stream produced by
//   the RS232-to-AXIS receiver, removes SLIP framing (RFC 1055) and emits the decoded payload
//   as an AXI stream with olast marking end of frame. Malformed or oversize frames are truncated,
//   flagged on oerror and counted. Feeds the command/packet layer of the host link.
// PARAMETERS
//   MAX_LEN    256   maximum payload bytes per frame; a longer frame is truncated and flagged
//   ERR_WIDTH  16    width of the saturating error counter
// PORTS
//   clock      in   1          single system clock, all logic on rising edge
//   reset      in   1          asynchronous, active-high reset
//   idata      in   8          SLIP-encoded byte from the RS232 receiver
//   ivalid     in   1          idata valid
//   iready     out  1          decoder accepts idata this cycle
//   odata      out  8          decoded payload byte
//   ovalid     out  1          odata valid
//   olast      out  1          odata is the final byte of its frame
//   oerror     out  1          qualified by ovalid&&olast: frame was truncated or malformed
//   oready     in   1          downstream accepts odata
//   errcount   out  ERR_WIDTH  frames flagged with oerror since reset, saturates at all-ones
// BEHAVIOUR
//   Reset: ovalid=0, olast=0, oerror=0, odata=0, errcount=0, hold empty, state=IDLE, len=0.
//   Codes: END=C0, ESC=DB, ESC_END=DC, ESC_ESC=DD. DB DC->C0, DB DD->DB, other bytes literal.
//   Handshake: input byte consumed when ivalid&&iready; output transfer when ovalid&&oready.
//     iready = !ovalid || oready (conservative; combinational from oready only).
//     ovalid/odata/olast/oerror stay stable while ovalid&&!oready.
//   One-byte hold register: a decoded byte is held until the next event shows whether it is
//     last. New decoded byte with hold full -> emit hold (olast=0), hold <= new byte.
//     END with hold full -> emit hold (olast=1, oerror=0), hold empty, len=0, state IDLE.
//     END with hold empty -> ignored (empty frames and leading/repeated END are dropped).
//   Latency: a payload byte appears on odata the cycle after the following byte/END is consumed.
//   States:
//     IDLE    no frame open. Literal -> hold, len=1, DATA. ESC -> ESCAPE. END -> stay.
//     DATA    literal -> hold/emit as above, len++. ESC -> ESCAPE. END -> close frame, IDLE.
//     ESCAPE  DC/DD -> decoded byte as literal, back to DATA. END -> protocol error: emit
//             hold with olast=1,oerror=1 (if hold empty, count only), IDLE. Any other byte ->
//             error: emit hold olast=1,oerror=1, DISCARD.
//     DISCARD drop every byte except END; END -> IDLE, nothing emitted.
//   Length: len counts decoded bytes of the open frame (width clog2(MAX_LEN+1)). Decoded byte
//     arriving when len==MAX_LEN -> emit hold with olast=1,oerror=1, drop byte, DISCARD.
//     Frames of exactly MAX_LEN bytes pass with oerror=0.
//   errcount increments once per flagged frame (including errors with empty hold); saturates.
//   Simultaneous output transfer and new emit in the same cycle is legal (full throughput,
//     one byte per clock). No byte is ever lost or duplicated on backpressure.
//   Reset mid-frame: all state cleared immediately; partial frame is discarded, no olast emitted.
// STRUCTURE
//   Shared package slip_pkg: localparams SLIP_END, SLIP_ESC, SLIP_ESC_END, SLIP_ESC_ESC and the
//   2-bit state encoding (IDLE, DATA, ESCAPE, DISCARD).
//   One sub-module: axis_out_reg (1-deep output register with {data,last,error}, ovalid,
//   oready, load strobe and iready generation); decoder FSM, hold and counters stay at top level.
// TESTING
//   1. C0 01 02 03 C0, oready=1 -> 01,02,03 out; olast only on 03; oerror=0; errcount=0.
//   2. 01 DB DC DB DD C0 -> 01, C0, DB; olast on DB; oerror=0.
//   3. C0 C0 C0 then 7E C0 -> no output for empty frames; single byte 7E with olast=1.
//   4. 05 DB 07 08 C0 09 C0 -> 05 olast=1 oerror=1; 07,08 dropped; 09 olast=1 oerror=0; errcount=1.
//   5. MAX_LEN=4: 11 22 33 44 55 66 C0 -> 11,22,33,44 with olast=1,oerror=1 on 44; then
//      11 22 33 44 C0 -> four bytes, oerror=0.
//   6. Random oready duty 30% over 1000 random frames vs. reference model -> identical byte/last/
//      error sequence; assert reset during a frame -> outputs 0 next cycle, next frame clean.

Source files
------------

// File: rtl/slip_pkg.sv
// Shared SLIP code points, decoder state encoding and the output beat layout.
package slip_pkg;

  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DATA    = 2'd1;
  localparam logic [1:0] ST_ESCAPE  = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       error;
  } out_beat_t;

endpackage

// File: rtl/axis_out_reg.sv
// One-deep AXI-stream output register. A load replaces the beat and raises
// ovalid; a transfer without a new load drops ovalid. iready tells the
// producer a load is safe this cycle.
module axis_out_reg
  import slip_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      load,
  input  out_beat_t load_beat,
  input  logic      oready,
  output out_beat_t beat,
  output logic      ovalid,
  output logic      iready
);

  out_beat_t beat_q, beat_d;
  logic      ovalid_q, ovalid_d;

  // Next-state: load wins over drain so a transfer and a new beat can share a cycle.
  always_comb begin
    beat_d   = beat_q;
    ovalid_d = ovalid_q;
    if (load) begin
      beat_d   = load_beat;
      ovalid_d = 1'b1;
    end else if (oready) begin
      ovalid_d = 1'b0;
    end
  end

  // Output register; contents stay frozen while stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      beat_q   <= beat_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign beat   = beat_q;
  assign ovalid = ovalid_q;
  assign iready = !ovalid_q || oready;

endmodule

// File: rtl/axis_slip_decoder.sv
// SLIP (RFC 1055) frame decoder between the RS232 byte receiver and the
// packet layer. A one-byte hold register delays each payload byte until the
// next event reveals whether it ends the frame.
module axis_slip_decoder
  import slip_pkg::*;
#(
  parameter int MAX_LEN   = 256,
  parameter int ERR_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           idata,
  input  logic                 ivalid,
  output logic                 iready,
  output logic [7:0]           odata,
  output logic                 ovalid,
  output logic                 olast,
  output logic                 oerror,
  input  logic                 oready,
  output logic [ERR_WIDTH-1:0] errcount
);

  localparam int              LEN_W   = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [1:0]           state_q, state_d;
  logic [7:0]           hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [ERR_WIDTH-1:0] errcount_q, errcount_d;

  logic      accept;
  logic      dec_vld;
  logic [7:0] dec_byte;
  logic      err_frame;
  logic      load;
  out_beat_t load_beat;
  out_beat_t beat;

  assign accept = ivalid && iready;

  // Decoder FSM: classify the consumed byte, then apply the decoded-byte and
  // error-close actions, which are shared across states.
  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    hold_vld_d     = hold_vld_q;
    len_d          = len_q;
    errcount_d     = errcount_q;
    dec_vld        = 1'b0;
    dec_byte       = idata;
    err_frame      = 1'b0;
    load           = 1'b0;
    load_beat.data  = hold_q;
    load_beat.last  = 1'b0;
    load_beat.error = 1'b0;

    if (accept) begin
      case (state_q)
        ST_IDLE, ST_DATA: begin
          if (idata == SLIP_END) begin
            // Closing an empty frame (hold empty) emits nothing.
            load           = hold_vld_q;
            load_beat.last = 1'b1;
            hold_vld_d     = 1'b0;
            len_d          = '0;
            state_d        = ST_IDLE;
          end else if (idata == SLIP_ESC) begin
            state_d = ST_ESCAPE;
          end else begin
            dec_vld = 1'b1;
          end
        end
        ST_ESCAPE: begin
          if (idata == SLIP_ESC_END) begin
            dec_vld  = 1'b1;
            dec_byte = SLIP_END;
          end else if (idata == SLIP_ESC_ESC) begin
            dec_vld  = 1'b1;
            dec_byte = SLIP_ESC;
          end else begin
            err_frame = 1'b1;
            state_d   = (idata == SLIP_END) ? ST_IDLE : ST_DISCARD;
          end
        end
        default: begin
          if (idata == SLIP_END) state_d = ST_IDLE;
        end
      endcase

      if (dec_vld) begin
        if (len_q == LEN_MAX) begin
          // Oversize: the held byte closes the frame as truncated.
          err_frame = 1'b1;
          state_d   = ST_DISCARD;
        end else begin
          load       = hold_vld_q;
          hold_d     = dec_byte;
          hold_vld_d = 1'b1;
          len_d      = len_q + 1'b1;
          state_d    = ST_DATA;
        end
      end

      if (err_frame) begin
        load            = hold_vld_q;
        load_beat.last  = 1'b1;
        load_beat.error = 1'b1;
        hold_vld_d      = 1'b0;
        len_d           = '0;
        if (errcount_q != '1) errcount_d = errcount_q + 1'b1;
      end
    end
  end

  // Decoder state, hold register, frame length and error counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      len_q      <= '0;
      errcount_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      len_q      <= len_d;
      errcount_q <= errcount_d;
    end
  end

  axis_out_reg u_out (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .load_beat (load_beat),
    .oready    (oready),
    .beat      (beat),
    .ovalid    (ovalid),
    .iready    (iready)
  );

  assign odata    = beat.data;
  assign olast    = beat.last;
  assign oerror   = beat.error;
  assign errcount = errcount_q;

endmodule

// File: tb/tb_axis_slip_decoder.sv
// Directed and randomized bench for axis_slip_decoder with a small MAX_LEN.
module tb_axis_slip_decoder;

  localparam int MAXL = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  idata = 8'h00;
  logic        ivalid = 1'b0;
  logic        iready;
  logic [7:0]  odata;
  logic        ovalid;
  logic        olast;
  logic        oerror;
  logic        oready = 1'b1;
  logic [15:0] errcount;

  axis_slip_decoder #(.MAX_LEN(MAXL), .ERR_WIDTH(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .idata    (idata),
    .ivalid   (ivalid),
    .iready   (iready),
    .odata    (odata),
    .ovalid   (ovalid),
    .olast    (olast),
    .oerror   (oerror),
    .oready   (oready),
    .errcount (errcount)
  );

  always #5 clock = ~clock;

  logic [7:0] in_q[$];
  logic [9:0] out_q[$];
  logic [9:0] exp_q[$];
  int         duty = 100;
  bit         in_acc = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         exp_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive inputs just after the rising edge.
  always @(posedge clock) begin
    #1;
    if (in_acc && in_q.size() > 0) void'(in_q.pop_front());
    if (reset) begin
      ivalid = 1'b0;
    end else begin
      ivalid = (in_q.size() > 0);
      idata  = (in_q.size() > 0) ? in_q[0] : 8'h00;
    end
    oready = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
  end

  // Sample handshakes on the falling edge; they complete at the next rising edge.
  always @(negedge clock) begin
    in_acc = !reset && ivalid && iready;
    if (!reset && ovalid && oready) out_q.push_back({odata, olast, oerror});
  end

  task automatic put_n(input int n, input logic [63:0] v);
    for (int i = 0; i < n; i++) in_q.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic want(input logic [7:0] d, input logic l, input logic e);
    exp_q.push_back({d, l, e});
  endtask

  task automatic enc(input logic [7:0] b);
    if (b == 8'hC0) begin in_q.push_back(8'hDB); in_q.push_back(8'hDC); end
    else if (b == 8'hDB) begin in_q.push_back(8'hDB); in_q.push_back(8'hDD); end
    else in_q.push_back(b);
  endtask

  task automatic run_check(input string tag, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (in_q.size() == 0 && !ivalid && !ovalid) begin
        done = 1'b1;
        break;
      end
    end
    check_eq({tag, " done"}, 32'(done), 32'd1);
    check_eq({tag, " count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      check_eq(tag, 32'(out_q[i]), 32'(exp_q[i]));
    out_q.delete();
    exp_q.delete();
  endtask

  initial begin : main
    int L, k, n;
    bit flag, endvar;
    logic [7:0] pl [8];
    logic [7:0] xx;
    int r;

    repeat (3) @(negedge clock);
    check_eq("rst ovalid", 32'(ovalid), 0);
    check_eq("rst olast", 32'(olast), 0);
    check_eq("rst oerror", 32'(oerror), 0);
    check_eq("rst odata", 32'(odata), 0);
    check_eq("rst errcount", 32'(errcount), 0);
    check_eq("rst iready", 32'(iready), 1);
    @(posedge clock); #2; reset = 1'b0;

    put_n(5, 64'hC0_01_02_03_C0);
    want(8'h01, 0, 0); want(8'h02, 0, 0); want(8'h03, 1, 0);
    run_check("basic", 200);
    check_eq("basic errcount", 32'(errcount), 0);

    put_n(6, 64'h01_DB_DC_DB_DD_C0);
    want(8'h01, 0, 0); want(8'hC0, 0, 0); want(8'hDB, 1, 0);
    run_check("escape", 200);

    put_n(5, 64'hC0_C0_C0_7E_C0);
    want(8'h7E, 1, 0);
    run_check("empty", 200);

    put_n(7, 64'h05_DB_07_08_C0_09_C0);
    want(8'h05, 1, 1); want(8'h09, 1, 0);
    run_check("bad_esc", 200);
    check_eq("bad_esc errcount", 32'(errcount), 1);

    put_n(7, 64'h11_22_33_44_55_66_C0);
    want(8'h11, 0, 0); want(8'h22, 0, 0); want(8'h33, 0, 0); want(8'h44, 1, 1);
    run_check("oversize", 200);
    check_eq("oversize errcount", 32'(errcount), 2);

    put_n(5, 64'h11_22_33_44_C0);
    want(8'h11, 0, 0); want(8'h22, 0, 0); want(8'h33, 0, 0); want(8'h44, 1, 0);
    run_check("exact_max", 200);
    check_eq("exact_max errcount", 32'(errcount), 2);

    put_n(2, 64'hDB_C0);
    run_check("esc_end_empty", 200);
    check_eq("esc_end_empty errcount", 32'(errcount), 3);

    exp_err = 3;
    duty = 30;
    for (int f = 0; f < 1000; f++) begin
      L      = $urandom_range(0, 6);
      k      = ($urandom_range(0, 3) == 0) ? $urandom_range(0, L) : -1;
      endvar = 1'($urandom_range(0, 1));
      for (int i = 0; i < L; i++) begin
        r = $urandom_range(0, 3);
        pl[i] = (r == 0) ? 8'hC0 : (r == 1) ? 8'hDB : 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 3) == 0) in_q.push_back(8'hC0);
      for (int i = 0; i < ((k >= 0) ? k : L); i++) enc(pl[i]);
      if (k >= 0) begin
        in_q.push_back(8'hDB);
        if (endvar) begin
          in_q.push_back(8'hC0);
        end else begin
          do xx = 8'($urandom_range(0, 255));
          while (xx == 8'hDC || xx == 8'hDD || xx == 8'hC0);
          in_q.push_back(xx);
          for (int i = k; i < L; i++) enc(pl[i]);
          in_q.push_back(8'hC0);
        end
      end else begin
        in_q.push_back(8'hC0);
      end
      if (k >= 0 && k <= MAXL) begin n = k; flag = 1'b1; end
      else if (L > MAXL) begin n = MAXL; flag = 1'b1; end
      else begin n = L; flag = 1'b0; end
      for (int i = 0; i < n; i++)
        want(pl[i], (i == n - 1), flag && (i == n - 1));
      if (flag) exp_err++;
    end
    run_check("random", 60000);
    check_eq("random errcount", 32'(errcount), 32'(exp_err));

    duty = 100;
    put_n(3, 64'h21_22_23);
    repeat (3) @(negedge clock);
    @(posedge clock); #2;
    reset = 1'b1;
    in_q.delete();
    @(negedge clock);
    check_eq("midrst ovalid", 32'(ovalid), 0);
    check_eq("midrst olast", 32'(olast), 0);
    check_eq("midrst oerror", 32'(oerror), 0);
    check_eq("midrst odata", 32'(odata), 0);
    check_eq("midrst errcount", 32'(errcount), 0);
    @(posedge clock); #2;
    reset = 1'b0;
    out_q.delete();
    exp_q.delete();
    put_n(2, 64'h7E_C0);
    want(8'h7E, 1, 0);
    run_check("post_rst", 200);
    check_eq("post_rst errcount", 32'(errcount), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
